// File: rtl/arena_uart_tx.sv
// arena_uart_tx: snapshots arena/bomb/player state on a strobe rising edge and streams it as an 8N1 UART packet.
// Optional ARENA_TX_CHECKSUM_EN appends an XOR checksum byte after byte 42.
module arena_uart_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 115200,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_snap_stb,
  input  logic [99:0] i_arena_0,
  input  logic [99:0] i_bombs_0,
  input  logic [99:0] i_bombs_1,
  input  logic [3:0] i_playerAx,
  input  logic [3:0] i_playerAy,
  input  logic [3:0] i_playerBx,
  input  logic [3:0] i_playerBy,
  input  logic [1:0] i_healthA,
  input  logic [1:0] i_healthB,
  input  logic [1:0] i_game_state,
  output logic o_tx,
  output logic o_busy,
  output logic o_drop
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
`ifdef ARENA_TX_CHECKSUM_EN
  localparam int L = 44;
`else
  localparam int L = 43;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic stb_q, stb_rise, tick;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [5:0] idx;
  logic [7:0] sh, cur;
  logic [L-1:0][7:0] pkt, pkt_d;
  assign stb_rise = i_snap_stb & ~stb_q;
  assign tick = cnt == CW'(DIV - 1);
`ifdef ARENA_TX_CHECKSUM_EN
  logic [7:0] chk;
  assign pkt_d = {8'h00, 2'b00, i_game_state, i_healthA, i_healthB, i_playerBx, i_playerBy,
                  i_playerAx, i_playerAy, 4'b0, i_bombs_1, 4'b0, i_bombs_0, 4'b0, i_arena_0, HDR};
  assign cur = idx == 6'(L - 1) ? chk : pkt[idx];
  always_ff @(posedge clk)
    if (rst || (state == IDLE && stb_rise)) chk <= '0;
    else if (state == START && tick) chk <= chk ^ cur;
`else
  assign pkt_d = {2'b00, i_game_state, i_healthA, i_healthB, i_playerBx, i_playerBy,
                  i_playerAx, i_playerAy, 4'b0, i_bombs_1, 4'b0, i_bombs_0, 4'b0, i_arena_0, HDR};
  assign cur = pkt[idx];
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = stb_rise ? START : IDLE;
      START:   state_n = tick ? DATA : START;
      DATA:    state_n = tick && bit_cnt == 3'd7 ? STOP : DATA;
      default: state_n = tick ? (idx == 6'(L - 1) ? IDLE : START) : STOP;
    endcase
  end
  always_comb begin
    o_tx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
    o_busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (state == IDLE && stb_rise) pkt <= pkt_d;
  // The byte is fetched at the end of its start bit, so the snapshot is already stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_drop <= 1'b0;
    end else begin
      stb_q <= i_snap_stb;
      o_drop <= stb_rise && state != IDLE;
      cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
      if (state == IDLE && stb_rise) idx <= '0;
      if (state == START && tick) sh <= cur;
      if (state == DATA && tick) begin
        sh <= sh >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && tick) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_arena_uart_tx.sv
// tb_arena_uart_tx: directed checks of snapshot capture, framing, drop handling and reset for arena_uart_tx.
module tb_arena_uart_tx;
  localparam int DIV = 10;
`ifdef ARENA_TX_CHECKSUM_EN
  localparam int L = 44;
`else
  localparam int L = 43;
`endif
  logic clk = 1'b0, rst = 1'b1, stb = 1'b1;
  logic [99:0] arena = '0, bombs0 = '0, bombs1 = '0;
  logic [3:0] ax = '0, ay = '0, bx = '0, by = '0;
  logic [1:0] ha = '0, hb = '0, gs = '0;
  logic tx, busy, drop;
  int n_tests = 0, n_fail = 0, drop_n = 0, bad = 0, busy_n = 0;
  logic [7:0] rx [0:43];
  logic [7:0] exp_b [0:43];
  always #5 clk = ~clk;
  always @(negedge clk) if (drop) drop_n++;
  arena_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .HDR(8'hA5)) dut (
    .clk(clk), .rst(rst), .i_snap_stb(stb),
    .i_arena_0(arena), .i_bombs_0(bombs0), .i_bombs_1(bombs1),
    .i_playerAx(ax), .i_playerAy(ay), .i_playerBx(bx), .i_playerBy(by),
    .i_healthA(ha), .i_healthB(hb), .i_game_state(gs),
    .o_tx(tx), .o_busy(busy), .o_drop(drop)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic build_exp();
    logic [7:0] x;
    logic [99:0] m;
    x = '0;
    for (int j = 0; j < 43; j++) begin
      if (j == 0) exp_b[j] = 8'hA5;
      else if (j < 40) begin
        m = (j - 1) / 13 == 0 ? arena : (j - 1) / 13 == 1 ? bombs0 : bombs1;
        for (int b = 0; b < 8; b++) begin
          int p;
          p = ((j - 1) % 13) * 8 + b;
          exp_b[j][b] = p < 100 ? m[p] : 1'b0;
        end
      end
      else if (j == 40) exp_b[j] = {ax, ay};
      else if (j == 41) exp_b[j] = {bx, by};
      else exp_b[j] = {2'b00, gs, ha, hb};
      x ^= exp_b[j];
    end
    exp_b[43] = x;
  endtask
  task automatic launch();
    @(negedge clk) stb = 1'b0;
    @(negedge clk) stb = 1'b1;
  endtask
  task automatic capture();
    bad = 0;
    busy_n = 0;
    for (int j = 0; j < L; j++)
      for (int t = 0; t < 10; t++) begin
        logic v;
        v = 1'b0;
        for (int c = 0; c < DIV; c++) begin
          @(negedge clk);
          if (busy) busy_n++;
          if (c == 0) v = tx;
          else if (tx !== v) bad++;
        end
        if (t == 0 && v !== 1'b0) bad++;
        else if (t == 9 && v !== 1'b1) bad++;
        else if (t > 0 && t < 9) rx[j][t-1] = v;
      end
    @(negedge clk);
    if (busy) busy_n++;
  endtask
  task automatic check_pkt(input string tag);
    for (int j = 0; j < L; j++) check($sformatf("%s byte %0d", tag, j), rx[j], exp_b[j]);
    check({tag, " framing"}, bad, 0);
    check({tag, " busy cycles"}, busy_n, L * 10 * DIV);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset drop", drop, 0);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy || !tx) bad++;
    end
    check("held strobe no launch", bad, 0);
    arena = 100'h1;
    ax = 4'd1; ay = 4'd1; bx = 4'd8; by = 4'd8; ha = 2'd3; hb = 2'd3; gs = 2'd0;
    build_exp();
    launch();
    capture();
    check_pkt("basic");
    check("basic hdr", rx[0], 8'hA5);
    check("basic arena lsb", rx[1], 8'h01);
    check("basic arena top", rx[13], 8'h00);
    check("basic A", rx[40], 8'h11);
    check("basic B", rx[41], 8'h88);
    check("basic health", rx[42], 8'h0F);
`ifdef ARENA_TX_CHECKSUM_EN
    check("basic checksum", rx[43], 8'h32);
`endif
    check("basic no drop", drop_n, 0);
    arena = {1'b1, 99'b0};
    build_exp();
    launch();
    capture();
    check("bit99 byte13", rx[13], 8'h08);
    check("bit99 byte12", rx[12], 8'h00);
    check_pkt("bit99");
    arena = 100'hF_0123_4567_89AB_CDEF_FEDC_BA98;
    bombs0 = 100'hA_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    bombs1 = 100'h3_C3C3_0000_FFFF_1234_8765_0F0F;
    ax = 4'd9; ay = 4'd2; bx = 4'd0; by = 4'd7; ha = 2'd1; hb = 2'd2; gs = 2'd3;
    drop_n = 0;
    build_exp();
    launch();
    fork
      capture();
      begin
        repeat (100) @(negedge clk);
        stb = 1'b0;
        @(negedge clk) stb = 1'b1;
      end
    join
    check("drop pulse cycles", drop_n, 1);
    check_pkt("drop");
    arena = 100'h1_1111_2222_3333_4444_5555_6666;
    bombs0 = 100'h8_0000_0000_0000_0000_0000_0001;
    bombs1 = '0;
    ax = 4'd4; ay = 4'd5; bx = 4'd6; by = 4'd7; ha = 2'd2; hb = 2'd0; gs = 2'd1;
    build_exp();
    launch();
    fork
      capture();
      begin
        @(negedge clk);
        arena = ~arena; bombs0 = ~bombs0; bombs1 = ~bombs1;
        ax = ~ax; ay = ~ay; bx = ~bx; by = ~by; ha = ~ha; hb = ~hb; gs = ~gs;
      end
    join
    check_pkt("snapshot hold");
    build_exp();
    launch();
    repeat (5 * 10 * DIV + 35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset tx", tx, 1);
    check("mid reset busy", busy, 0);
    rst = 1'b0;
    launch();
    capture();
    check_pkt("after reset");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
